tx_nsym_calc: RTL

Computes the OFDM symbol count, pad-bit count and PPDU airtime for one transmit frame from its PSDU byte length and rate. Sits directly upstream of the shared integer divider in tx_intf: it builds the dividend (DATA-field bit count) and divisor (data bits per symbol), starts the divider, and post-processes the quotient and remainder. The results feed the PHY header builder and the TX duration logic.

---
 rtl/tx_nsym_calc.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/tx_nsym_calc.sv
// tx_nsym_calc: per-frame OFDM symbol count, pad bits and PPDU airtime.
// Builds the DATA-field bit count (dividend) and data bits per symbol
// (divisor), drives the shared integer divider and post-processes the
// quotient and remainder into nsym / npad / duration.
//
// Handshakes: a request transfers on a rising clk edge where in_valid and
// in_ready are both high; in_ready is high only in IDLE, and in_valid seen
// in any other state is dropped, never queued. div_start is a one-cycle
// pulse with div_x/div_y held until the divider answers; div_valid/div_dbz
// are only looked at in WAIT. out_valid is a one-cycle strobe with no
// backpressure, and out_* hold their value between strobes.
module tx_nsym_calc #(
    parameter int DIV_WIDTH = 16,
    parameter int TIMEOUT   = 2*DIV_WIDTH+8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [11:0]          in_len,
    input  logic                 in_ht,
    input  logic [3:0]           in_rate,
    output logic                 div_start,
    output logic [DIV_WIDTH-1:0] div_x,
    output logic [DIV_WIDTH-1:0] div_y,
    input  logic                 div_busy,
    input  logic                 div_valid,
    input  logic                 div_dbz,
    input  logic [DIV_WIDTH-1:0] div_q,
    input  logic [DIV_WIDTH-1:0] div_r,
    output logic                 out_valid,
    output logic [15:0]          out_nsym,
    output logic [15:0]          out_npad,
    output logic [15:0]          out_dur_us,
    output logic                 out_err,
    output logic [3:0]           dbg_status   // {div_busy, state}
);

    localparam int CW = $clog2(TIMEOUT+1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_POST   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                 state_q;
    logic [11:0]            len_q;
    logic                   ht_q;
    logic [3:0]             rate_q;
    logic [8:0]             ndbps_q;
    logic [DIV_WIDTH-1:0]   div_x_q;
    logic [DIV_WIDTH-1:0]   div_y_q;
    logic                   div_start_q;
    logic [CW-1:0]          cnt_q;
    logic [15:0]            q_q;
    logic [15:0]            r_q;
    logic [15:0]            nsym_q;
    logic [15:0]            npad_q;
    logic [15:0]            dur_q;
    logic                   err_q;
    logic                   out_valid_q;

    logic [8:0]             ndbps_d;
    logic [15:0]            bits_d;
    logic [15:0]            nsym_d;
    logic [15:0]            npad_d;
    logic [15:0]            dur_d;

    // Rate lookup and dividend from the captured request; 0 marks an invalid rate.
    always_comb begin
        ndbps_d = 9'd0;
        bits_d  = 16'd22 + {1'b0, len_q, 3'b000};
        if (ht_q) begin
            if (!rate_q[3]) begin
                case (rate_q[2:0])
                    3'd0:    ndbps_d = 9'd26;
                    3'd1:    ndbps_d = 9'd52;
                    3'd2:    ndbps_d = 9'd78;
                    3'd3:    ndbps_d = 9'd104;
                    3'd4:    ndbps_d = 9'd156;
                    3'd5:    ndbps_d = 9'd208;
                    3'd6:    ndbps_d = 9'd234;
                    default: ndbps_d = 9'd260;
                endcase
            end
        end else begin
            case (rate_q)
                4'hB:    ndbps_d = 9'd24;
                4'hF:    ndbps_d = 9'd36;
                4'hA:    ndbps_d = 9'd48;
                4'hE:    ndbps_d = 9'd72;
                4'h9:    ndbps_d = 9'd96;
                4'hD:    ndbps_d = 9'd144;
                4'h8:    ndbps_d = 9'd192;
                4'hC:    ndbps_d = 9'd216;
                default: ndbps_d = 9'd0;
            endcase
        end
    end

    // Quotient/remainder post-processing: round symbols up, pad the remainder out.
    always_comb begin
        nsym_d = q_q + {15'd0, (r_q != 16'd0)};
        npad_d = 16'd0;
        if (r_q != 16'd0) begin
            npad_d = {7'd0, ndbps_q} - r_q;
        end
        dur_d = (ht_q ? 16'd36 : 16'd20) + {nsym_d[13:0], 2'b00};
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= 12'd0;
            ht_q        <= 1'b0;
            rate_q      <= 4'd0;
            ndbps_q     <= 9'd0;
            div_x_q     <= '0;
            div_y_q     <= '0;
            div_start_q <= 1'b0;
            cnt_q       <= '0;
            q_q         <= 16'd0;
            r_q         <= 16'd0;
            nsym_q      <= 16'd0;
            npad_q      <= 16'd0;
            dur_q       <= 16'd0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            div_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        len_q   <= in_len;
                        ht_q    <= in_ht;
                        rate_q  <= in_rate;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    ndbps_q <= ndbps_d;
                    div_x_q <= DIV_WIDTH'(bits_d);
                    div_y_q <= DIV_WIDTH'(ndbps_d);
                    cnt_q   <= '0;
                    if (ndbps_d == 9'd0) begin
                        nsym_q      <= 16'd0;
                        npad_q      <= 16'd0;
                        dur_q       <= 16'd0;
                        err_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        div_start_q <= 1'b1;
                        state_q     <= S_START;
                    end
                end
                S_START: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // dbz beats a simultaneous valid.
                    if (div_dbz || (!div_valid && cnt_q == CW'(TIMEOUT))) begin
                        nsym_q      <= 16'd0;
                        npad_q      <= 16'd0;
                        dur_q       <= 16'd0;
                        err_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (div_valid) begin
                        q_q     <= div_q[15:0];
                        r_q     <= div_r[15:0];
                        state_q <= S_POST;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_POST: begin
                    nsym_q      <= nsym_d;
                    npad_q      <= npad_d;
                    dur_q       <= dur_d;
                    err_q       <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign div_start  = div_start_q;
    assign div_x      = div_x_q;
    assign div_y      = div_y_q;
    assign out_valid  = out_valid_q;
    assign out_nsym   = nsym_q;
    assign out_npad   = npad_q;
    assign out_dur_us = dur_q;
    assign out_err    = err_q;
    // div_busy has no control role; it is surfaced here for observation only.
    assign dbg_status = {div_busy, state_q};

endmodule
